adc_lane_align: RTL and testbench
=================================

Name: adc_lane_align

Overview:
- Parametrised successor to the fixed 2-channel x 12-bit x 4-sample ADC unpacker.
- Sits between the LVDS deserializer (rx_out / rx_outclock domain) and the DSP front end.
- Performs per-lane word alignment by driving deserializer bitslip against a known ADC training word.
- Remaps the bit-interleaved deserializer word into per-sample words and optionally converts offset-binary to two's complement.

Parameters:
- NBITS, 12, bits per ADC sample.
- NSAMP, 4, deserialization factor (samples per channel per word).
- NCH, 2, ADC channels (0 = Q, 1 = I).
- TRAIN_WORD, 4'b1000, expected NSAMP-bit lane word during training; must be rotation-aperiodic.
- SLIP_WAIT, 4, cycles waited after a bitslip before re-checking (≥1).
- MATCH_CNT, 8, consecutive all-lane matching valid words required for lock.

Derived values: NLANE = NCH*NBITS; W = NLANE*NSAMP.

Ports:
- clk  in  1  deserializer output clock (rx_outclock domain); only clock.
- rst  in  1  synchronous, active-high reset.
- rx_in  in  W  deserializer word; lane l = c*NBITS+b occupies [l*NSAMP +: NSAMP]; lane bit NSAMP-1 is the oldest sample.
- rx_valid  in  1  rx_in qualifier.
- align_start  in  1  one-cycle pulse that (re)starts training.
- fmt_twos  in  1  1: output two's complement (invert MSB); 0: offset binary passthrough.
- bitslip  out  NLANE  one-cycle per-lane slip pulses to the deserializer.
- aligned  out  1  all lanes locked.
- align_fail  out  1  at least one lane exhausted its slips.
- lane_fail  out  NLANE  per-lane failure mask.
- dout  out  NCH*NSAMP*NBITS  sample j = k*NCH+c at [j*NBITS +: NBITS].
- dout_valid  out  1  dout qualifier.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; slip and match counters 0.
- Remap: channel c, sample k, bit b = rx_in[(c*NBITS+b)*NSAMP + (NSAMP-1-k)]. Output order for defaults is Q0, I0, Q1, I1, …
- Datapath latency:
  - Stage 1 registers the remapped word, qualified by rx_valid.
  - Stage 2 applies fmt_twos (sampled at stage 2) and registers dout.
  - dout_valid = rx_valid delayed 2 cycles AND aligned at stage-1 capture.
  - dout keeps updating when dout_valid = 0; consumers must ignore it.
- FSM states:
  - IDLE: waits for align_start.
  - SETTLE: counts SLIP_WAIT cycles, then goes to CHECK.
  - CHECK: acts on the first rx_valid cycle. Each lane word is compared to TRAIN_WORD.
    - Any mismatching lane with slip_cnt < NSAMP-1: pulse bitslip for that lane only (exactly 1 cycle), increment its 2-bit-or-wider slip_cnt, clear the match counter, go to SETTLE.
    - Mismatching lane with slip_cnt = NSAMP-1: set its lane_fail bit and go to FAIL.
    - All lanes match: increment the match counter. On reaching MATCH_CNT go to LOCKED; otherwise stay in CHECK.
  - LOCKED: aligned = 1. No further comparison; mission data is not checked.
  - FAIL: align_fail = 1; lane_fail holds.
- align_start in any state (including mid-SETTLE or mid-CHECK):
  - Clears counters, aligned, align_fail and lane_fail.
  - Goes to SETTLE with no bitslip issued that cycle.
- Simultaneous fail and slip in one CHECK: the fail takes priority. No bitslip pulses are issued that cycle; lane_fail records every lane at its limit.
- rst mid-operation returns to IDLE immediately. Any bitslip pulse in progress is truncated to 0.
- Match counter saturates at MATCH_CNT and never wraps.

Optional Feature:
- Macro: ADC_ALIGN_ERRCNT_EN.
- When defined:
  - Adds output err_cnt (16 bits): saturating count of CHECK evaluations with any lane mismatch since the last align_start or rst.
  - Adds output slip_total (8 bits): saturating total bitslip pulses issued.
  - Both reset to 0.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Reset with defaults and rx_in = 0 -> all outputs 0, FSM IDLE, no bitslip for 10 cycles.
- All 24 lanes present 4'b1000, align_start pulse -> no bitslip; aligned = 1 after SLIP_WAIT + 8 valid words; dout_valid follows rx_valid by 2 cycles.
- Lane 5 presents 4'b0100 and the model rotates it one position per slip -> lane-5 bitslip pulses until its word reads 4'b1000, other lanes never slip, then aligned = 1 and align_fail = 0.
- Lane 0 stuck at 4'b1111 -> 3 slips, then align_fail = 1, lane_fail = 24'h000001, aligned = 0.
- Locked; rx_in carries Q0 = 12'h800, I0 = 12'h7FF, fmt_twos = 1 -> dout[11:0] = 12'h000 and dout[23:12] = 12'hFFF two cycles later. With fmt_twos = 0 -> dout[11:0] = 12'h800 and dout[23:12] = 12'h7FF.
- align_start during SETTLE after 2 slips -> counters cleared and no bitslip that cycle; rst asserted during a bitslip pulse -> bitslip = 0 next cycle and FSM IDLE.

Source files
------------

// File: rtl/adc_lane_align.sv
// adc_lane_align: LVDS deserializer word aligner and sample unpacker.
// Drives per-lane bitslip until every lane presents TRAIN_WORD for MATCH_CNT
// consecutive valid words, then remaps the bit-interleaved deserializer word
// into per-sample words (Q0, I0, Q1, I1, ...) with optional offset-binary to
// two's complement conversion.
// Optional feature macro: ADC_ALIGN_ERRCNT_EN adds err_cnt and slip_total.
module adc_lane_align #(
  parameter int NBITS     = 12,
  parameter int NSAMP     = 4,
  parameter int NCH       = 2,
  parameter logic [NSAMP-1:0] TRAIN_WORD = 4'b1000,
  parameter int SLIP_WAIT = 4,
  parameter int MATCH_CNT = 8,
  localparam int NLANE    = NCH * NBITS,
  localparam int W        = NLANE * NSAMP,
  localparam int DW       = NCH * NSAMP * NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     rx_in,
  input  logic             rx_valid,
  input  logic             align_start,
  input  logic             fmt_twos,
  output logic [NLANE-1:0] bitslip,
  output logic             aligned,
  output logic             align_fail,
  output logic [NLANE-1:0] lane_fail,
  output logic [DW-1:0]    dout,
  output logic             dout_valid
`ifdef ADC_ALIGN_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt,
  output logic [7:0]       slip_total
`endif
);

  // Slip counter must reach NSAMP-1 and be at least 2 bits wide.
  localparam int SCW = ($clog2(NSAMP) > 2) ? $clog2(NSAMP) : 2;
  localparam int MCW = $clog2(MATCH_CNT + 1);
  localparam int WCW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_LOCKED,
    S_FAIL
  } state_t;

  state_t           state;
  logic [SCW-1:0]   slip_cnt [NLANE];
  logic [MCW-1:0]   match_cnt;
  logic [WCW-1:0]   wait_cnt;

  logic [NLANE-1:0] mismatch;
  logic [NLANE-1:0] at_limit;
  logic [NLANE-1:0] fail_mask;

  logic [DW-1:0]    data_p1;
  logic             vld_p1;

  // Bit-interleaved deserializer word -> sample-ordered word.
  // Lane bit NSAMP-1 is the oldest sample, so sample k sits at NSAMP-1-k.
  function automatic logic [DW-1:0] remap(input logic [W-1:0] word);
    logic [DW-1:0] res;
    res = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < NSAMP; k++) begin
        for (int b = 0; b < NBITS; b++) begin
          res[(k*NCH + c)*NBITS + b] = word[(c*NBITS + b)*NSAMP + (NSAMP-1-k)];
        end
      end
    end
    return res;
  endfunction

  // Offset binary -> two's complement is an MSB inversion per sample.
  function automatic logic [DW-1:0] fmt_samples(input logic [DW-1:0] d,
                                                input logic twos);
    logic [DW-1:0]           res;
    logic signed [NBITS-1:0] s;
    res = '0;
    for (int j = 0; j < NCH*NSAMP; j++) begin
      s = signed'(d[j*NBITS +: NBITS]);
      if (twos) s[NBITS-1] = ~s[NBITS-1];
      res[j*NBITS +: NBITS] = s;
    end
    return res;
  endfunction

  // Match counter increment that sticks at MATCH_CNT.
  function automatic logic [MCW-1:0] sat_inc_match(input logic [MCW-1:0] v);
    return (v >= MCW'(MATCH_CNT)) ? MCW'(MATCH_CNT) : v + 1'b1;
  endfunction

  // Per-lane training word comparison and slip-limit detection.
  always_comb begin
    mismatch = '0;
    at_limit = '0;
    for (int l = 0; l < NLANE; l++) begin
      mismatch[l] = (rx_in[l*NSAMP +: NSAMP] != TRAIN_WORD);
      at_limit[l] = (slip_cnt[l] == SCW'(NSAMP-1));
    end
    fail_mask = mismatch & at_limit;
  end

  // Alignment FSM with registered bitslip/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      bitslip    <= '0;
      aligned    <= 1'b0;
      align_fail <= 1'b0;
      lane_fail  <= '0;
      match_cnt  <= '0;
      wait_cnt   <= '0;
      for (int l = 0; l < NLANE; l++) slip_cnt[l] <= '0;
    end else begin
      bitslip <= '0;
      if (align_start) begin
        state      <= S_SETTLE;
        aligned    <= 1'b0;
        align_fail <= 1'b0;
        lane_fail  <= '0;
        match_cnt  <= '0;
        wait_cnt   <= '0;
        for (int l = 0; l < NLANE; l++) slip_cnt[l] <= '0;
      end else begin
        case (state)
          S_SETTLE: begin
            if (wait_cnt == WCW'(SLIP_WAIT-1)) state <= S_CHECK;
            else wait_cnt <= wait_cnt + 1'b1;
          end
          S_CHECK: begin
            if (rx_valid) begin
              if (|fail_mask) begin
                // A lane out of slips wins over any pending slips this cycle.
                lane_fail  <= fail_mask;
                align_fail <= 1'b1;
                state      <= S_FAIL;
              end else if (|mismatch) begin
                bitslip   <= mismatch;
                match_cnt <= '0;
                wait_cnt  <= '0;
                state     <= S_SETTLE;
                for (int l = 0; l < NLANE; l++) begin
                  if (mismatch[l]) slip_cnt[l] <= slip_cnt[l] + 1'b1;
                end
              end else begin
                match_cnt <= sat_inc_match(match_cnt);
                if (match_cnt >= MCW'(MATCH_CNT-1)) begin
                  aligned <= 1'b1;
                  state   <= S_LOCKED;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ADC_ALIGN_ERRCNT_EN
  logic check_eval;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_add_pop(input logic [7:0] v,
                                             input logic [NLANE-1:0] m);
    int s;
    s = int'(v);
    for (int i = 0; i < NLANE; i++) s = s + int'(m[i]);
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  assign check_eval = (state == S_CHECK) && rx_valid && !align_start;

  // Saturating mismatch-evaluation and bitslip-pulse statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt    <= '0;
      slip_total <= '0;
    end else begin
      if (align_start) err_cnt <= '0;
      else if (check_eval && |mismatch) err_cnt <= sat_inc16(err_cnt);
      if (check_eval && !(|fail_mask) && |mismatch)
        slip_total <= sat_add_pop(slip_total, mismatch);
    end
  end
`endif

  // ---- stage p1: remap, captured on valid words ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= rx_valid & aligned;
      if (rx_valid) data_p1 <= remap(rx_in);
    end
  end

  // ---- stage p2: format conversion, registered output ----
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      dout_valid <= vld_p1;
      dout       <= fmt_samples(data_p1, fmt_twos);
    end
  end

endmodule

// File: tb/tb_adc_lane_align.sv
// Directed bench for adc_lane_align with default parameters. A small
// deserializer model rotates a lane word left by one on each bitslip pulse.
module tb_adc_lane_align;
  localparam int NBITS = 12;
  localparam int NSAMP = 4;
  localparam int NCH   = 2;
  localparam int NLANE = NCH * NBITS;
  localparam int W     = NLANE * NSAMP;
  localparam int DW    = NCH * NSAMP * NBITS;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     rx_in;
  logic             rx_valid;
  logic             align_start;
  logic             fmt_twos;
  logic [NLANE-1:0] bitslip;
  logic             aligned;
  logic             align_fail;
  logic [NLANE-1:0] lane_fail;
  logic [DW-1:0]    dout;
  logic             dout_valid;
`ifdef ADC_ALIGN_ERRCNT_EN
  logic [15:0]      err_cnt;
  logic [7:0]       slip_total;
`endif

  logic [NSAMP-1:0] lane_words [NLANE];
  int               slips [NLANE];
  int               n_tests = 0;
  int               n_fail  = 0;

  adc_lane_align dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .rx_valid    (rx_valid),
    .align_start (align_start),
    .fmt_twos    (fmt_twos),
    .bitslip     (bitslip),
    .aligned     (aligned),
    .align_fail  (align_fail),
    .lane_fail   (lane_fail),
    .dout        (dout),
    .dout_valid  (dout_valid)
`ifdef ADC_ALIGN_ERRCNT_EN
    ,
    .err_cnt     (err_cnt),
    .slip_total  (slip_total)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_rx();
    for (int l = 0; l < NLANE; l++) rx_in[l*NSAMP +: NSAMP] = lane_words[l];
  endtask

  task automatic set_all(input logic [NSAMP-1:0] w);
    for (int l = 0; l < NLANE; l++) lane_words[l] = w;
  endtask

  task automatic clear_slips();
    for (int l = 0; l < NLANE; l++) slips[l] = 0;
  endtask

  function automatic int other_slips(input int skip);
    int s;
    s = 0;
    for (int l = 0; l < NLANE; l++) if (l != skip) s += slips[l];
    return s;
  endfunction

  // Advance one clock; outputs are looked at 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bitslip != '0) begin
      for (int l = 0; l < NLANE; l++) begin
        if (bitslip[l]) begin
          slips[l]++;
          lane_words[l] = {lane_words[l][NSAMP-2:0], lane_words[l][NSAMP-1]};
        end
      end
      build_rx();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    align_start = 1'b1;
    tick();
    align_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(aligned || align_fail) && n < budget) begin
      tick();
      n++;
    end
    check("wait_done", 128'(aligned | align_fail), 128'(1));
  endtask

  task automatic set_sample(input int c, input int k, input logic [NBITS-1:0] v);
    for (int b = 0; b < NBITS; b++) rx_in[(c*NBITS + b)*NSAMP + (NSAMP-1-k)] = v[b];
  endtask

  initial begin
    int pulses;
    int n;
    rst = 1'b1;
    rx_in = '0;
    rx_valid = 1'b0;
    align_start = 1'b0;
    fmt_twos = 1'b0;
    set_all('0);
    clear_slips();

    // Reset state and idle behaviour
    tick();
    tick();
    tick();
    check("rst_bitslip", 128'(bitslip), 128'(0));
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bitslip != '0) pulses++;
    end
    check("idle_pulses", 128'(pulses), 128'(0));
    check("rst_aligned", 128'(aligned), 128'(0));
    check("rst_align_fail", 128'(align_fail), 128'(0));
    check("rst_lane_fail", 128'(lane_fail), 128'(0));
    check("rst_dout", 128'(dout), 128'(0));
    check("rst_dout_valid", 128'(dout_valid), 128'(0));

    // All lanes already aligned: lock after SLIP_WAIT + MATCH_CNT edges
    set_all(4'b1000);
    build_rx();
    rx_valid = 1'b1;
    clear_slips();
    pulse_start();
    for (int i = 0; i < 11; i++) tick();
    check("aligned_early", 128'(aligned), 128'(0));
    tick();
    check("aligned_at_12", 128'(aligned), 128'(1));
    check("train_slips", 128'(other_slips(-1)), 128'(0));
    check("train_fail", 128'(align_fail), 128'(0));

    // dout_valid follows rx_valid by two cycles once locked
    rx_valid = 1'b0;
    tick();
    tick();
    tick();
    check("dv_idle", 128'(dout_valid), 128'(0));
    rx_valid = 1'b1;
    tick();
    check("dv_lat1", 128'(dout_valid), 128'(0));
    rx_valid = 1'b0;
    tick();
    check("dv_lat2", 128'(dout_valid), 128'(1));
    tick();
    check("dv_drop", 128'(dout_valid), 128'(0));

    // Remap and format conversion on mission data
    rx_in = '0;
    set_sample(0, 0, 12'h800);
    set_sample(1, 0, 12'h7FF);
    set_sample(0, 1, 12'h123);
    set_sample(1, 1, 12'hABC);
    rx_valid = 1'b1;
    fmt_twos = 1'b1;
    tick();
    tick();
    check("twos_q0", 128'(dout[11:0]), 128'(12'h000));
    check("twos_i0", 128'(dout[23:12]), 128'(12'hFFF));
    check("twos_q1", 128'(dout[35:24]), 128'(12'h923));
    check("twos_i1", 128'(dout[47:36]), 128'(12'h2BC));
    fmt_twos = 1'b0;
    tick();
    tick();
    check("ob_q0", 128'(dout[11:0]), 128'(12'h800));
    check("ob_i0", 128'(dout[23:12]), 128'(12'h7FF));
    check("ob_i1", 128'(dout[47:36]), 128'(12'hABC));
    check("ob_dv", 128'(dout_valid), 128'(1));

    // Lane 5 one position off: exactly one slip on lane 5 only
    do_reset();
    set_all(4'b1000);
    lane_words[5] = 4'b0100;
    build_rx();
    clear_slips();
    pulse_start();
    wait_done(300);
    check("l5_aligned", 128'(aligned), 128'(1));
    check("l5_fail", 128'(align_fail), 128'(0));
    check("l5_slips", 128'(slips[5]), 128'(1));
    check("l5_other_slips", 128'(other_slips(5)), 128'(0));

    // Lane 0 stuck: three slips then failure
    do_reset();
    set_all(4'b1000);
    lane_words[0] = 4'b1111;
    build_rx();
    clear_slips();
    pulse_start();
    wait_done(300);
    check("stuck_fail", 128'(align_fail), 128'(1));
    check("stuck_lane_fail", 128'(lane_fail), 128'(24'h000001));
    check("stuck_aligned", 128'(aligned), 128'(0));
    check("stuck_slips", 128'(slips[0]), 128'(3));
    check("stuck_other", 128'(other_slips(0)), 128'(0));

    // align_start during SETTLE after two slips restarts the slip budget
    do_reset();
    clear_slips();
    pulse_start();
    n = 0;
    while (slips[0] < 2 && n < 300) begin
      tick();
      n++;
    end
    check("two_slips", 128'(slips[0]), 128'(2));
    tick();
    align_start = 1'b1;
    tick();
    align_start = 1'b0;
    check("restart_noslip", 128'(bitslip), 128'(0));
    check("restart_fail", 128'(align_fail), 128'(0));
    check("restart_lane_fail", 128'(lane_fail), 128'(0));
    clear_slips();
    wait_done(300);
    check("restart_slips", 128'(slips[0]), 128'(3));
    check("restart_end_fail", 128'(align_fail), 128'(1));

    // rst during a bitslip pulse truncates it and parks the FSM
    do_reset();
    clear_slips();
    pulse_start();
    n = 0;
    while (bitslip == '0 && n < 300) begin
      tick();
      n++;
    end
    check("pulse_seen", 128'(bitslip), 128'(24'h000001));
    rst = 1'b1;
    tick();
    check("rst_trunc", 128'(bitslip), 128'(0));
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bitslip != '0) pulses++;
    end
    check("post_rst_idle", 128'(pulses), 128'(0));
    check("post_rst_aligned", 128'(aligned), 128'(0));
    check("post_rst_fail", 128'(align_fail), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
